// File: rtl/int_logic_pipe_if.sv
// Issue-side and result-side handshake bundle for int_logic_pipe.
// The master drives operations and out_ready; the slave (execution unit) drives in_ready and results.
interface int_logic_pipe_if #(
    parameter int WIDTH = 64,
    parameter int LIT_W = 8,
    parameter int TAG_W = 6
) ();
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       in_fct;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic             in_lit_v;
    logic [LIT_W-1:0] in_lit;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cond;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_fct, in_op1, in_op2, in_lit_v, in_lit, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_cond, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_fct, in_op1, in_op2, in_lit_v, in_lit, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_cond, out_illegal, out_tag
    );
endinterface

// File: rtl/int_logic_pipe.sv
// Two-stage integer logic / conditional-move unit with valid/ready back-pressure.
// Define INTL_CMOV_EN to build the CMOV family; otherwise those codes decode as illegal.
module int_logic_pipe #(
    parameter int WIDTH    = 64,
    parameter int LIT_W    = 8,
    parameter int LIT_SEXT = 0,
    parameter int TAG_W    = 6
) (
    input logic           clk,
    input logic           rst_n,
    int_logic_pipe_if.slave bus
);
    logic             s1Valid;
    logic [6:0]       s1Fct;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [TAG_W-1:0] s1Tag;

    logic             s2Valid;
    logic [WIDTH-1:0] s2Data;
    logic             s2Cond;
    logic             s2Ill;
    logic [TAG_W-1:0] s2Tag;

    logic             s2Adv;
    logic             accept;
    logic [WIDTH-1:0] litExt;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] resData;
    logic             resCond;
    logic             resIll;

    // S1 can only drain when S2 drains, so in_ready depends combinationally on out_ready.
    assign s2Adv        = !s2Valid || bus.out_ready;
    assign bus.in_ready = !s1Valid || s2Adv;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        litExt = '0;
        litExt[LIT_W-1:0] = bus.in_lit;
        if (LIT_SEXT != 0) begin
            for (int i = LIT_W; i < WIDTH; i++) begin
                litExt[i] = bus.in_lit[LIT_W-1];
            end
        end
    end

    assign opB = bus.in_lit_v ? litExt : bus.in_op2;

`ifdef INTL_CMOV_EN
    logic aZero;
    logic aNeg;
    assign aZero = (s1A == '0);
    assign aNeg  = s1A[WIDTH-1];
`endif

    always_comb begin
        resData = '0;
        resCond = 1'b0;
        resIll  = 1'b0;
        case (s1Fct)
            7'h00: begin resData = s1A & s1B;    resCond = 1'b1; end
            7'h08: begin resData = s1A & ~s1B;   resCond = 1'b1; end
            7'h20: begin resData = s1A | s1B;    resCond = 1'b1; end
            7'h28: begin resData = s1A | ~s1B;   resCond = 1'b1; end
            7'h40: begin resData = s1A ^ s1B;    resCond = 1'b1; end
            7'h48: begin resData = ~(s1A ^ s1B); resCond = 1'b1; end
`ifdef INTL_CMOV_EN
            7'h14: begin resData = s1B; resCond = s1A[0];          end
            7'h16: begin resData = s1B; resCond = !s1A[0];         end
            7'h24: begin resData = s1B; resCond = aZero;           end
            7'h26: begin resData = s1B; resCond = !aZero;          end
            7'h44: begin resData = s1B; resCond = aNeg;            end
            7'h46: begin resData = s1B; resCond = !aNeg;           end
            7'h64: begin resData = s1B; resCond = aZero || aNeg;   end
            7'h66: begin resData = s1B; resCond = !aZero && !aNeg; end
`endif
            default: resIll = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Fct   <= '0;
            s1A     <= '0;
            s1B     <= '0;
            s1Tag   <= '0;
            s2Valid <= 1'b0;
            s2Data  <= '0;
            s2Cond  <= 1'b0;
            s2Ill   <= 1'b0;
            s2Tag   <= '0;
        end else begin
            if (s2Adv) begin
                s2Valid <= s1Valid;
                if (s1Valid) begin
                    s2Data <= resData;
                    s2Cond <= resCond;
                    s2Ill  <= resIll;
                    s2Tag  <= s1Tag;
                end
            end
            if (accept) begin
                s1Valid <= 1'b1;
                s1Fct   <= bus.in_fct;
                s1A     <= bus.in_op1;
                s1B     <= opB;
                s1Tag   <= bus.in_tag;
            end else if (s2Adv) begin
                s1Valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = s2Valid;
    assign bus.out_data    = s2Data;
    assign bus.out_cond    = s2Cond;
    assign bus.out_illegal = s2Ill;
    assign bus.out_tag     = s2Tag;
endmodule

// File: tb/tb_int_logic_pipe.sv
// Directed bench for int_logic_pipe: vector table, literal extension, back-pressure and reset.
module tb_int_logic_pipe;
    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int_logic_pipe_if #(.WIDTH(64), .LIT_W(8), .TAG_W(6)) bus0 ();
    int_logic_pipe_if #(.WIDTH(64), .LIT_W(8), .TAG_W(6)) bus1 ();

    int_logic_pipe #(.WIDTH(64), .LIT_W(8), .LIT_SEXT(0), .TAG_W(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    int_logic_pipe #(.WIDTH(64), .LIT_W(8), .LIT_SEXT(1), .TAG_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    typedef struct packed {
        logic [6:0]  fct;
        logic [63:0] a;
        logic [63:0] b;
        logic        litV;
        logic [7:0]  lit;
        logic [63:0] expData;
        logic        expCond;
        logic        expIll;
    } vec_t;

    localparam logic [63:0] CB = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] PA = 64'hFF00_FF00_FF00_FF00;
    localparam logic [63:0] PB = 64'h0F0F_0F0F_0F0F_0F0F;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [6:0] f, input logic [63:0] a, input logic [63:0] b,
                                input logic lv, input logic [7:0] l, input logic [63:0] d,
                                input logic c, input logic il);
        vec_t v;
        v.fct = f; v.a = a; v.b = b; v.litV = lv; v.lit = l;
        v.expData = d; v.expCond = c; v.expIll = il;
        return v;
    endfunction

    function automatic vec_t cm(input logic [6:0] f, input logic [63:0] a, input logic c);
`ifdef INTL_CMOV_EN
        return mk(f, a, CB, 1'b0, 8'h00, CB, c, 1'b0);
`else
        return mk(f, a, CB, 1'b0, 8'h00, 64'h0, 1'b0 & c, 1'b1);
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.in_valid = 1'b0; bus0.in_fct = '0; bus0.in_op1 = '0; bus0.in_op2 = '0;
        bus0.in_lit_v = 1'b0; bus0.in_lit = '0; bus0.in_tag = '0;
    endtask

    int          nextTag;
    int          expTag;
    int          stallSeen;
    logic        acc;
    logic        hs;
    logic        holdPend;
    logic [63:0] holdData;
    logic [5:0]  holdTag;

    initial begin
        nChecks = 0;
        nErr    = 0;
        rst_n   = 1'b0;
        idle0();
        bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_fct = '0; bus1.in_op1 = '0; bus1.in_op2 = '0;
        bus1.in_lit_v = 1'b0; bus1.in_lit = '0; bus1.in_tag = '0; bus1.out_ready = 1'b1;

        vecs.push_back(mk(7'h00, PA, PB, 1'b0, 8'h00, 64'h0F00_0F00_0F00_0F00, 1'b1, 1'b0));
        vecs.push_back(mk(7'h08, PA, PB, 1'b0, 8'h00, 64'hF000_F000_F000_F000, 1'b1, 1'b0));
        vecs.push_back(mk(7'h20, PA, PB, 1'b0, 8'h00, 64'hFF0F_FF0F_FF0F_FF0F, 1'b1, 1'b0));
        vecs.push_back(mk(7'h40, PA, PB, 1'b0, 8'h00, 64'hF00F_F00F_F00F_F00F, 1'b1, 1'b0));
        vecs.push_back(mk(7'h48, PA, PB, 1'b0, 8'h00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b1, 1'b0));
        vecs.push_back(mk(7'h28, 64'h12, 64'h5555, 1'b1, 8'h80, 64'hFFFF_FFFF_FFFF_FF7F, 1'b1, 1'b0));
        vecs.push_back(mk(7'h01, PA, PB, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1));
        vecs.push_back(cm(7'h44, 64'h0, 1'b0));
        vecs.push_back(cm(7'h44, 64'h1, 1'b0));
        vecs.push_back(cm(7'h44, NEG,   1'b1));
        vecs.push_back(cm(7'h46, 64'h0, 1'b1));
        vecs.push_back(cm(7'h46, 64'h1, 1'b1));
        vecs.push_back(cm(7'h46, NEG,   1'b0));
        vecs.push_back(cm(7'h64, 64'h0, 1'b1));
        vecs.push_back(cm(7'h64, 64'h1, 1'b0));
        vecs.push_back(cm(7'h64, NEG,   1'b1));
        vecs.push_back(cm(7'h66, 64'h0, 1'b0));
        vecs.push_back(cm(7'h66, 64'h1, 1'b1));
        vecs.push_back(cm(7'h66, NEG,   1'b0));
        vecs.push_back(cm(7'h24, 64'h0, 1'b1));
        vecs.push_back(cm(7'h26, 64'h0, 1'b0));
        vecs.push_back(cm(7'h14, 64'h1, 1'b1));
        vecs.push_back(cm(7'h16, 64'h1, 1'b0));

        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst out_valid", 64'(bus0.out_valid), 64'h0);
        chk("rst out_data", bus0.out_data, 64'h0);
        chk("rst out_cond", 64'(bus0.out_cond), 64'h0);
        chk("rst out_illegal", 64'(bus0.out_illegal), 64'h0);
        chk("rst out_tag", 64'(bus0.out_tag), 64'h0);
        chk("rst in_ready", 64'(bus0.in_ready), 64'h1);

        // One op at a time: out_valid must appear on the second edge after accept, not the first.
        for (int i = 0; i < vecs.size(); i++) begin
            bus0.in_valid = 1'b1; bus0.in_fct = vecs[i].fct; bus0.in_op1 = vecs[i].a;
            bus0.in_op2 = vecs[i].b; bus0.in_lit_v = vecs[i].litV; bus0.in_lit = vecs[i].lit;
            bus0.in_tag = 6'(i + 7);
            step();
            idle0();
            chk($sformatf("vec%0d early valid", i), 64'(bus0.out_valid), 64'h0);
            step();
            chk($sformatf("vec%0d valid", i), 64'(bus0.out_valid), 64'h1);
            chk($sformatf("vec%0d data", i), bus0.out_data, vecs[i].expData);
            chk($sformatf("vec%0d cond", i), 64'(bus0.out_cond), 64'(vecs[i].expCond));
            chk($sformatf("vec%0d illegal", i), 64'(bus0.out_illegal), 64'(vecs[i].expIll));
            chk($sformatf("vec%0d tag", i), 64'(bus0.out_tag), 64'(i + 7));
            step();
        end

        // Sign-extended literal on the second instance.
        bus1.in_valid = 1'b1; bus1.in_fct = 7'h28; bus1.in_op1 = 64'h12;
        bus1.in_op2 = 64'h5555; bus1.in_lit_v = 1'b1; bus1.in_lit = 8'h80; bus1.in_tag = 6'd3;
        step();
        bus1.in_valid = 1'b0;
        step();
        chk("sext valid", 64'(bus1.out_valid), 64'h1);
        chk("sext data", bus1.out_data, 64'h0000_0000_0000_007F);
        chk("sext cond", 64'(bus1.out_cond), 64'h1);
        step();

        // Back-pressure stream: out_ready low in loop cycles 3..6.
        nextTag = 0; expTag = 0; stallSeen = 0; holdPend = 1'b0;
        holdData = '0; holdTag = '0;
        for (int c = 0; c < 40 && expTag < 6; c++) begin
            bus0.out_ready = !(c >= 3 && c <= 6);
            bus0.in_valid  = (nextTag < 6);
            bus0.in_fct    = 7'h00;
            bus0.in_op1    = 64'(nextTag) + 64'h100;
            bus0.in_op2    = '1;
            bus0.in_lit_v  = 1'b0;
            bus0.in_tag    = 6'(nextTag);
            #1;
            acc = bus0.in_valid && bus0.in_ready;
            hs  = bus0.out_valid && bus0.out_ready;
            holdPend = bus0.out_valid && !bus0.out_ready;
            holdData = bus0.out_data;
            holdTag  = bus0.out_tag;
            if (!bus0.in_ready) stallSeen++;
            if (hs) begin
                chk($sformatf("bp tag%0d", expTag), 64'(bus0.out_tag), 64'(expTag));
                chk($sformatf("bp data%0d", expTag), bus0.out_data, 64'(expTag) + 64'h100);
                expTag++;
            end
            step();
            if (acc) nextTag++;
            if (holdPend) begin
                chk("bp hold valid", 64'(bus0.out_valid), 64'h1);
                chk("bp hold tag", 64'(bus0.out_tag), 64'(holdTag));
                chk("bp hold data", bus0.out_data, holdData);
            end
        end
        idle0();
        bus0.out_ready = 1'b1;
        chk("bp all delivered", 64'(expTag), 64'd6);
        chk("bp in_ready dropped", 64'(stallSeen > 0), 64'h1);
        step();
        chk("bp drained", 64'(bus0.out_valid), 64'h0);

        // Mid-stream reset with two ops in flight.
        bus0.in_valid = 1'b1; bus0.in_fct = 7'h40; bus0.in_op1 = '1; bus0.in_op2 = '0;
        bus0.in_tag = 6'd9;
        step();
        bus0.in_tag = 6'd10;
        step();
        idle0();
        chk("pre-rst valid", 64'(bus0.out_valid), 64'h1);
        rst_n = 1'b0;
        step();
        chk("mid-rst out_valid", 64'(bus0.out_valid), 64'h0);
        chk("mid-rst out_data", bus0.out_data, 64'h0);
        chk("mid-rst out_cond", 64'(bus0.out_cond), 64'h0);
        chk("mid-rst out_tag", 64'(bus0.out_tag), 64'h0);
        rst_n = 1'b1;
        step();
        chk("post-rst in_ready", 64'(bus0.in_ready), 64'h1);
        chk("post-rst out_valid", 64'(bus0.out_valid), 64'h0);
        step();
        chk("post-rst still idle", 64'(bus0.out_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule

// File: doc/int_logic_pipe.md
# int_logic_pipe

Pipelined, parametrised integer-logic execution unit: the next generation of the single-stage integer logic/CMOV datapath in the EXU. It accepts one operation per cycle over a valid/ready handshake, computes the bitwise logical ops and the conditional-move family over a WIDTH-bit datapath, and returns result, write-condition and tag two cycles later with full back-pressure support. Sits between the issue stage and the EXU result bus.

## Interface
Parameters:
- WIDTH, 64, datapath width in bits (≥ 8)
- LIT_W, 8, literal field width (≤ WIDTH)
- LIT_SEXT, 0, 1 = literal sign-extended, 0 = zero-extended
- TAG_W, 6, destination tag width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_fct  in  7  function code
- in_op1  in  WIDTH  Ra (logic input 1 / CMOV condition operand)
- in_op2  in  WIDTH  Rb
- in_lit_v  in  1  1 = use in_lit in place of in_op2
- in_lit  in  LIT_W  literal
- in_tag  in  TAG_W  destination tag, carried unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_cond  out  1  1 = write out_data to destination
- out_illegal  out  1  function code not implemented
- out_tag  out  TAG_W  tag of the result

## Operation
- Operand B = in_lit_v ? extend(in_lit) : in_op2; extension per LIT_SEXT.
- Codes (hex): AND 00 A&B; BIC 08 A&~B; BIS 20 A|B; ORNOT 28 A|~B; XOR 40 A^B; EQV 48 ~(A^B).
- CMOV codes, out_data = B, out_cond from A: LBS 14 A[0]; LBC 16 ~A[0]; EQ 24 A==0; NE 26 A!=0; LT 44 A[W-1]; GE 46 ~A[W-1]; LE 64 A==0 | A[W-1]; GT 66 A!=0 & ~A[W-1].
- Non-CMOV legal ops: out_cond = 1. Any other code: out_data = 0, out_cond = 0, out_illegal = 1.
- Stage S1: captures fct, A, B, tag on accept (in_valid & in_ready). Stage S2: registers decoded result.
- Each stage holds a valid bit; S2 advances when empty or out_ready; S1 advances into S2 when S2 advances; in_ready = !S1.valid | S1 advances.
- Outputs held stable while out_valid & !out_ready.
- Reset: all valid bits 0; out_valid = 0, out_data = 0, out_cond = 0, out_illegal = 0, out_tag = 0; in_ready = 1 on the first cycle after reset deasserts.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+2.
- Throughput: 1 op/cycle with out_ready held high.
- out_ready low with both stages full: in_ready = 0 in the same cycle (combinational from out_ready); no op lost or duplicated.
- Simultaneous out handshake and in accept with both stages full: S2 ← S1, S1 ← new, in the same cycle.
- rst_n low mid-stream: all in-flight ops discarded at that edge; no out_valid until new accepts.
- in_* ignored when in_ready = 0.

## Configuration
- INTL_CMOV_EN defined: all eight CMOV codes implemented as above.
- INTL_CMOV_EN undefined: CMOV decode and condition logic removed; codes 14/16/24/26/44/46/64/66 treated as illegal (out_data = 0, out_cond = 0, out_illegal = 1). Logic ops unchanged.

## Test plan
- WIDTH=64: AND A=0xFF00FF00_FF00FF00, B=0x0F0F0F0F_0F0F0F0F → out_data 0x0F000F00_0F000F00, out_cond 1, out_valid exactly 2 cycles after accept.
- ORNOT with in_lit_v=1, in_lit=0x80, LIT_SEXT=0 → B=0x80, out_data = A | 0xFFFFFFFF_FFFFFF7F; repeat with LIT_SEXT=1 → B=0xFFFF..FF80, out_data = A | 0x7F.
- CMOVLT/GE/LE/GT with A = 0, 1, 0x8000_0000_0000_0000 → out_cond LT 0/0/1, GE 1/1/0, LE 1/0/1, GT 0/1/0; out_data = B each time.
- Code 0x01 → out_illegal 1, out_cond 0, out_data 0; with INTL_CMOV_EN undefined, CMOVEQ (0x24) → same.
- Back-pressure: stream 6 ops with tags 0..5, out_ready low cycles 3–6 → in_ready drops once both stages full, results emerge in tag order 0..5, none duplicated.
- Assert rst_n low for one cycle with 2 ops in flight → out_valid 0 next cycle, all outputs 0, in_ready 1 after release.
